// File: rtl/e_mdu.sv
// ---------------------------------------------------------------------------
// e_mdu -- execute-stage multiply/divide unit with HI/LO registers.
//
// Runs mult/multu/div/divu over a fixed latency (MULT_CYCLES or DIV_CYCLES)
// and owns the architectural HI/LO pair. mthi/mtlo write HI/LO in one cycle;
// mfhi/mflo read them combinationally onto E_mdu_out.
//
// Ports
//   clk          clock, all state updates on posedge
//   rst          synchronous active-high reset
//   E_mdu_op     decoded op: 0 none, 1 mult, 2 multu, 3 div, 4 divu,
//                5 mthi, 6 mtlo, 7 mfhi, 8 mflo, 9-15 none
//   E_Rdata1     rs operand (dividend / multiplicand / mthi-mtlo source)
//   E_Rdata2     rt operand (divisor / multiplier)
//   M_REQ        flush: the E-stage instruction is squashed this cycle
//   E_busy       registered, high while a mult/div is in flight
//   E_mdu_stall  E_busy, or a mult/div op presented this cycle
//   E_HI, E_LO   registered HI/LO
//   E_mdu_out    HI for mfhi, LO for mflo, else 0
// ---------------------------------------------------------------------------
module e_mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  E_mdu_op,
  input  logic [31:0] E_Rdata1,
  input  logic [31:0] E_Rdata2,
  input  logic        M_REQ,
  output logic        E_busy,
  output logic        E_mdu_stall,
  output logic [31:0] E_HI,
  output logic [31:0] E_LO,
  output logic [31:0] E_mdu_out
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  localparam logic [3:0] OpMult  = 4'd1;
  localparam logic [3:0] OpMultu = 4'd2;
  localparam logic [3:0] OpDiv   = 4'd3;
  localparam logic [3:0] OpDivu  = 4'd4;
  localparam logic [3:0] OpMthi  = 4'd5;
  localparam logic [3:0] OpMtlo  = 4'd6;
  localparam logic [3:0] OpMfhi  = 4'd7;
  localparam logic [3:0] OpMflo  = 4'd8;

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [3:0]        op_q, op_d;
  logic [31:0]       src_a_q, src_a_d;
  logic [31:0]       src_b_q, src_b_d;
  logic [31:0]       hi_q, hi_d;
  logic [31:0]       lo_q, lo_d;

  // -------------------------------------------------------------------------
  // Datapath on the latched operands; only sampled on the final busy cycle.
  // -------------------------------------------------------------------------
  logic        is_mul;
  logic        mul_signed;
  logic [63:0] mul_a, mul_b, prod;

  logic        div_signed;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [31:0] quo_mag, rem_mag;
  logic [31:0] quo, rem;
  logic        div_by_zero;

  always_comb begin
    is_mul     = (op_q == OpMult) || (op_q == OpMultu);
    mul_signed = (op_q == OpMult);
    // Sign- or zero-extend to 64 bits; the low 64 bits of the product are
    // then correct for both signed and unsigned operands.
    mul_a = mul_signed ? {{32{src_a_q[31]}}, src_a_q} : {32'd0, src_a_q};
    mul_b = mul_signed ? {{32{src_b_q[31]}}, src_b_q} : {32'd0, src_b_q};
    prod  = mul_a * mul_b;
  end

  always_comb begin
    div_signed  = (op_q == OpDiv);
    a_neg       = div_signed & src_a_q[31];
    b_neg       = div_signed & src_b_q[31];
    // Work on magnitudes so 0x80000000 / -1 needs no signed-overflow special case:
    // |0x80000000| = 2^31 still fits unsigned, and negating 2^31 wraps back to it.
    a_mag       = a_neg ? (32'd0 - src_a_q) : src_a_q;
    b_mag       = b_neg ? (32'd0 - src_b_q) : src_b_q;
    div_by_zero = (src_b_q == 32'd0);
    quo_mag     = div_by_zero ? 32'd0 : (a_mag / b_mag);
    rem_mag     = div_by_zero ? 32'd0 : (a_mag % b_mag);
    // Quotient truncates toward zero; remainder takes the dividend's sign.
    quo         = (a_neg ^ b_neg) ? (32'd0 - quo_mag) : quo_mag;
    rem         = a_neg ? (32'd0 - rem_mag) : rem_mag;
  end

  // -------------------------------------------------------------------------
  // Control: IDLE accepts starts and mthi/mtlo; BUSY counts down and commits.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    src_a_d = src_a_q;
    src_b_d = src_b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    unique case (state_q)
      StIdle: begin
        // A flushed instruction leaves no trace.
        if (!M_REQ) begin
          case (E_mdu_op)
            OpMult, OpMultu, OpDiv, OpDivu: begin
              op_d    = E_mdu_op;
              src_a_d = E_Rdata1;
              src_b_d = E_Rdata2;
              cnt_d   = ((E_mdu_op == OpMult) || (E_mdu_op == OpMultu))
                        ? CntW'(MULT_CYCLES) : CntW'(DIV_CYCLES);
              state_d = StBusy;
            end
            OpMthi:  hi_d = E_Rdata1;
            OpMtlo:  lo_d = E_Rdata1;
            default: ;
          endcase
        end
      end

      StBusy: begin
        // New ops and M_REQ are deliberately ignored here: a started
        // operation always completes.
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d = StIdle;
          if (is_mul) begin
            hi_d = prod[63:32];
            lo_d = prod[31:0];
          end else if (!div_by_zero) begin
            hi_d = rem;
            lo_d = quo;
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= 4'd0;
      src_a_q <= 32'd0;
      src_b_q <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      src_a_q <= src_a_d;
      src_b_q <= src_b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  always_comb begin
    E_busy      = (state_q == StBusy);
    E_HI        = hi_q;
    E_LO        = lo_q;
    E_mdu_stall = E_busy || ((E_mdu_op >= OpMult) && (E_mdu_op <= OpDivu));
    case (E_mdu_op)
      OpMfhi:  E_mdu_out = hi_q;
      OpMflo:  E_mdu_out = lo_q;
      default: E_mdu_out = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_e_mdu.sv
module tb_e_mdu;

  localparam int MultN = 5;
  localparam int DivN  = 10;

  logic        clk;
  logic        rst;
  logic [3:0]  E_mdu_op;
  logic [31:0] E_Rdata1;
  logic [31:0] E_Rdata2;
  logic        M_REQ;
  logic        E_busy;
  logic        E_mdu_stall;
  logic [31:0] E_HI;
  logic [31:0] E_LO;
  logic [31:0] E_mdu_out;

  int checks = 0;
  int passed = 0;

  // Reference architectural state.
  logic [31:0] hi_m = 32'd0;
  logic [31:0] lo_m = 32'd0;

  e_mdu #(.MULT_CYCLES(MultN), .DIV_CYCLES(DivN)) dut (
    .clk         (clk),
    .rst         (rst),
    .E_mdu_op    (E_mdu_op),
    .E_Rdata1    (E_Rdata1),
    .E_Rdata2    (E_Rdata2),
    .M_REQ       (M_REQ),
    .E_busy      (E_busy),
    .E_mdu_stall (E_mdu_stall),
    .E_HI        (E_HI),
    .E_LO        (E_LO),
    .E_mdu_out   (E_mdu_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference result of a mult/div, from plain 64-bit arithmetic.
  task automatic model_exec(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, p, q, r;
    logic [63:0] up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      4'd1: begin p = sa * sb; hi_m = p[63:32]; lo_m = p[31:0]; end
      4'd2: begin up = {32'd0, a} * {32'd0, b}; hi_m = up[63:32]; lo_m = up[31:0]; end
      4'd3: if (b != 0) begin q = sa / sb; r = sa % sb; lo_m = q[31:0]; hi_m = r[31:0]; end
      4'd4: if (b != 0) begin lo_m = a / b; hi_m = a % b; end
      default: ;
    endcase
  endtask

  function automatic logic is_start(input logic [3:0] op);
    return (op >= 4'd1) && (op <= 4'd4);
  endfunction

  // Wait for E_busy to drop; returns how many cycles it was high.
  task automatic wait_idle(output int n);
    n = 0;
    while (E_busy === 1'b1 && n < 40) begin
      n++;
      tick();
    end
  endtask

  // Present one instruction for one cycle, then follow it to completion.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic mreq);
    int n;
    logic [31:0] old_hi, old_lo;
    old_hi = hi_m;
    old_lo = lo_m;
    E_mdu_op = op; E_Rdata1 = a; E_Rdata2 = b; M_REQ = mreq;
    #1;
    check({tag, "_stall"}, {31'd0, E_mdu_stall}, {31'd0, is_start(op)});
    check({tag, "_out"}, E_mdu_out, (op == 4'd7) ? hi_m : (op == 4'd8) ? lo_m : 32'd0);
    tick();
    E_mdu_op = 4'd0; M_REQ = 1'b0;
    if (!mreq && op == 4'd5) hi_m = a;
    if (!mreq && op == 4'd6) lo_m = a;
    if (!mreq && is_start(op)) begin
      check({tag, "_old_hi"}, E_HI, old_hi);
      check({tag, "_old_lo"}, E_LO, old_lo);
      wait_idle(n);
      check({tag, "_busy_len"}, n, (op <= 4'd2) ? MultN : DivN);
      model_exec(op, a, b);
    end else begin
      check({tag, "_nobusy"}, {31'd0, E_busy}, 32'd0);
    end
    check({tag, "_hi"}, E_HI, hi_m);
    check({tag, "_lo"}, E_LO, lo_m);
  endtask

  initial begin
    int n;
    logic [3:0]  op;
    logic [31:0] a, b;
    logic        mq;

    rst = 1'b1; E_mdu_op = 4'd0; E_Rdata1 = 32'd0; E_Rdata2 = 32'd0; M_REQ = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check("rst_busy", {31'd0, E_busy}, 32'd0);
    check("rst_hi", E_HI, 32'd0);
    check("rst_lo", E_LO, 32'd0);
    check("rst_out", E_mdu_out, 32'd0);

    // Directed test-plan items.
    run_op("mult", 4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
    check("mult_hi_k", E_HI, 32'hFFFF_FFFF);
    check("mult_lo_k", E_LO, 32'hFFFF_FFFA);
    run_op("multu", 4'd2, 32'hFFFF_FFFE, 32'd3, 1'b0);
    check("multu_hi_k", E_HI, 32'h0000_0002);
    check("multu_lo_k", E_LO, 32'hFFFF_FFFA);
    run_op("div", 4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
    check("div_lo_k", E_LO, 32'hFFFF_FFFD);
    check("div_hi_k", E_HI, 32'hFFFF_FFFF);
    run_op("divu", 4'd4, 32'd7, 32'd2, 1'b0);
    check("divu_lo_k", E_LO, 32'd3);
    check("divu_hi_k", E_HI, 32'd1);
    run_op("divovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    check("divovf_lo_k", E_LO, 32'h8000_0000);
    check("divovf_hi_k", E_HI, 32'd0);
    run_op("mthi", 4'd5, 32'h1234_5678, 32'd0, 1'b0);
    run_op("divz", 4'd4, 32'd5, 32'd0, 1'b0);
    check("divz_hi_k", E_HI, 32'h1234_5678);
    run_op("flush_mult", 4'd1, 32'd9, 32'd9, 1'b1);
    run_op("flush_mtlo", 4'd6, 32'hDEAD_BEEF, 32'd0, 1'b1);

    // M_REQ in busy cycle 3 must not disturb the divide.
    E_mdu_op = 4'd3; E_Rdata1 = 32'd100; E_Rdata2 = 32'hFFFF_FFF9; tick();
    E_mdu_op = 4'd0;
    tick(); tick();
    M_REQ = 1'b1; tick(); M_REQ = 1'b0;
    wait_idle(n);
    model_exec(4'd3, 32'd100, 32'hFFFF_FFF9);
    check("mreq_busy_hi", E_HI, hi_m);
    check("mreq_busy_lo", E_LO, lo_m);

    // mthi and a new start presented while busy are ignored; mfhi reads old HI.
    E_mdu_op = 4'd2; E_Rdata1 = 32'd1000; E_Rdata2 = 32'd1000; tick();
    check("busy_mfhi_old", E_mdu_out, 32'd0);
    E_mdu_op = 4'd7; #1;
    check("busy_mfhi", E_mdu_out, hi_m);
    E_mdu_op = 4'd5; E_Rdata1 = 32'hBAD0_BAD0; tick();
    E_mdu_op = 4'd1; E_Rdata1 = 32'd3; E_Rdata2 = 32'd3; tick();
    E_mdu_op = 4'd0;
    wait_idle(n);
    check("busy_ign_len", n, MultN - 2);
    model_exec(4'd2, 32'd1000, 32'd1000);
    check("busy_ign_hi", E_HI, hi_m);
    check("busy_ign_lo", E_LO, lo_m);

    // Reset during busy cycle 4 of a div discards it.
    E_mdu_op = 4'd4; E_Rdata1 = 32'd77; E_Rdata2 = 32'd5; tick();
    E_mdu_op = 4'd0;
    tick(); tick(); tick();
    rst = 1'b1; tick(); rst = 1'b0;
    hi_m = 32'd0; lo_m = 32'd0;
    check("rst_mid_busy", {31'd0, E_busy}, 32'd0);
    check("rst_mid_hi", E_HI, 32'd0);
    check("rst_mid_lo", E_LO, 32'd0);
    for (int i = 0; i < 12; i++) tick();
    check("rst_late_hi", E_HI, 32'd0);
    check("rst_late_lo", E_LO, 32'd0);

    run_op("mtlo", 4'd6, 32'hA5A5_A5A5, 32'd0, 1'b0);
    run_op("mflo", 4'd8, 32'd0, 32'd0, 1'b0);

    // Back-to-back start in the first idle cycle.
    run_op("b2b_a", 4'd1, 32'd12345, 32'hFFFF_0001, 1'b0);
    run_op("b2b_b", 4'd3, 32'hFFFF_8000, 32'd123, 1'b0);

    // Randomized mix.
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 10));
      a  = $urandom();
      b  = $urandom();
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 9));
        3: a = -32'($urandom_range(1, 1000));
        default: ;
      endcase
      mq = ($urandom_range(0, 7) == 0);
      run_op("rand", op, a, b, mq);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/e_mdu.md
# e_mdu

Execute-stage multiply/divide unit for the five-stage MIPS pipeline. It consumes the operands and instruction latched by the D/E pipeline register. It runs mult, multu, div and divu over a fixed multi-cycle latency and holds the HI/LO architectural registers. It also returns HI/LO to the E-stage result mux for mfhi/mflo. The hazard unit uses its busy indication to stall the D stage.

## Interface
- MULT_CYCLES, 5, busy cycles for mult/multu (≥1)
- DIV_CYCLES, 10, busy cycles for div/divu (≥1)

- clk  input  1  clock; all state updates on posedge
- rst  input  1  synchronous, active-high reset
- E_mdu_op  input  4  decoded op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo, 9–15 treated as none
- E_Rdata1  input  32  forwarded rs value (dividend / multiplicand / mthi-mtlo source)
- E_Rdata2  input  32  forwarded rt value (divisor / multiplier)
- M_REQ  input  1  exception/interrupt flush; the E-stage instruction is squashed this cycle
- E_busy  output  1  registered; high while a mult/div is in flight
- E_mdu_stall  output  1  combinational: E_busy, or E_mdu_op in 1..4 this cycle; hazard unit stalls any MDU instruction in D on it
- E_HI  output  32  registered HI
- E_LO  output  32  registered LO
- E_mdu_out  output  32  combinational: HI if op=7, LO if op=8, else 0

## Operation
- States: IDLE (E_busy=0) and BUSY (E_busy=1), with a down-counter cnt and latched op/operands.
- Start: in IDLE with op 1–4 and M_REQ=0, latch E_Rdata1/E_Rdata2 and op at the edge. Load cnt with MULT_CYCLES or DIV_CYCLES and enter BUSY.
- BUSY: cnt decrements each cycle. At the edge where cnt==1, write HI/LO and return to IDLE.
- mult: {HI,LO} = signed 64-bit product. multu: unsigned product.
- div: LO = quotient truncated toward zero, HI = remainder with the dividend's sign. divu: unsigned quotient and remainder.
- Signed corner case: 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- Divide by zero (both div and divu): full busy latency still elapses; HI and LO are left unchanged.
- mthi/mtlo: in IDLE with M_REQ=0, write E_Rdata1 to HI or LO at the edge. There is no busy period.
- M_REQ=1: a start, mthi or mtlo presented that cycle is ignored with no state change.
- M_REQ during BUSY has no effect. An operation already started always completes.
- Op 1–6 presented while BUSY is ignored. The stall logic must prevent this; the block must not corrupt state if it happens.
- mfhi/mflo during BUSY return the old HI/LO value. The stall logic must prevent this case too.
- rst: E_busy=0, cnt=0, HI=0, LO=0, latched operands=0. rst overrides an in-flight operation, whose result is discarded. rst has priority over start and M_REQ.

## Timing
- Start sampled at edge T. E_busy is high for cycles T+1..T+N, where N is MULT_CYCLES or DIV_CYCLES. The new HI/LO are visible and E_busy=0 from cycle T+N+1.
- Back-to-back: a new start is accepted in cycle T+N+1.
- E_mdu_stall is high in cycle T (the start cycle) and in T+1..T+N.
- mthi/mtlo at edge T: the new value appears on E_HI/E_LO and through mfhi/mflo in cycle T+1.
- E_mdu_out is zero-latency from E_mdu_op and the current HI/LO.
- After reset, all outputs are 0 once rst is sampled.

## Test plan
- Reset, then mult 0xFFFFFFFE × 3 → E_busy high for exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA. Repeat with multu → HI=0x00000002, LO=0xFFFFFFFA.
- div −7 / 2 → E_busy 10 cycles; LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1). divu 7/2 → LO=3, HI=1. div 0x80000000 / −1 → LO=0x80000000, HI=0.
- mthi 0x12345678 then divu 5 / 0 → busy 10 cycles; HI stays 0x12345678 and LO is unchanged.
- mult presented with M_REQ=1 → E_busy stays 0 and HI/LO are unchanged. Start a div, then assert M_REQ during busy cycle 3 → the div completes with the correct result.
- rst asserted in cycle 4 of a div → next cycle E_busy=0, HI=LO=0, and no late write occurs. mtlo 0xA5A5A5A5 then mflo next cycle → E_mdu_out=0xA5A5A5A5.
